// File: rtl/gate_ex_pkg.sv
// rtl/gate_ex_pkg.sv - shared FSM state type and constants for the gate exerciser
package gate_ex_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_N_INPUTS    = 3;
  localparam int DEFAULT_HOLD_CYCLES = 4;

  localparam logic [7:0] AND3_TABLE = 8'b1000_0000;
  localparam logic [7:0] OR3_TABLE  = 8'b1111_1110;

endpackage

// File: rtl/hold_counter.sv
// rtl/hold_counter.sv - per-vector hold timer; tc_o marks the last hold clock
module hold_counter
  import gate_ex_pkg::*;
#(
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  assign tc_o = (count_q == LAST);

  // Wraps to zero on terminal count so the next vector starts a fresh hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - sweeps every stimulus value into a gate and checks it against a truth table
module gate_exerciser
  import gate_ex_pkg::*;
#(
  parameter int N_INPUTS    = DEFAULT_N_INPUTS,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [2**N_INPUTS-1:0]   exp_table,
  input  logic                     dut_o,
  output logic [N_INPUTS-1:0]      stim,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_INPUTS:0]        err_count,
  output logic                     fail_valid,
  output logic [N_INPUTS-1:0]      fail_vec
);

  localparam int N_VEC = 2**N_INPUTS;
  localparam logic [N_INPUTS-1:0] LAST_VEC = '1;

  state_e                state_q, state_d;
  logic [N_VEC-1:0]      table_q, table_d;
  logic [N_INPUTS-1:0]   stim_q, stim_d;
  logic [N_INPUTS:0]     err_q, err_d;
  logic                  fail_valid_q, fail_valid_d;
  logic [N_INPUTS-1:0]   fail_vec_q, fail_vec_d;
  logic                  pass_q, pass_d;
  logic                  hold_clear, hold_en, hold_tc;
  logic                  mismatch;

  hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (hold_clear),
    .en_i    (hold_en),
    .tc_o    (hold_tc)
  );

  assign mismatch = (dut_o != table_q[stim_q]);

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    stim_d       = stim_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    hold_clear   = 1'b0;
    hold_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          table_d      = exp_table;
          stim_d       = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          hold_clear   = 1'b1;
        end
      end
      ST_DRIVE: begin
        hold_en = 1'b1;
        if (hold_tc) begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!fail_valid_q) begin
              fail_valid_d = 1'b1;
              fail_vec_d   = stim_q;
            end
          end
          // The last vector stays on stim through DONE rather than wrapping.
          if (stim_q == LAST_VEC) begin
            state_d = ST_DONE;
            pass_d  = (err_d == '0);
          end else begin
            stim_d = stim_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stim_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      table_q      <= '0;
      stim_q       <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      stim_q       <= stim_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
    end
  end

  assign stim       = stim_q;
  assign busy       = (state_q == ST_DRIVE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_exerciser.sv
// tb/tb_gate_exerciser.sv - randomized self-checking bench for gate_exerciser (hold 4 and hold 1)
module tb_gate_exerciser;
  import gate_ex_pkg::*;

  localparam int N = 3;
  localparam int P = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;
  int stim_hist [64];

  logic       start_s [2];
  logic       rst_s   [2];
  logic [7:0] tbl_s   [2];
  int         mode_s  [2];
  logic [7:0] rnd_s   [2];
  logic [2:0] stim_w  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic       pass_w  [2];
  logic       fv_w    [2];
  logic       dut_o_w [2];
  logic [3:0] err_w   [2];
  logic [2:0] fvec_w  [2];

  function automatic void check(string name, int g, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", name, g, act, exp, $time);
    end
  endfunction

  // The gate under test: 0=AND3, 1=OR3, 2=stuck-at-0, otherwise a random truth table.
  function automatic logic gate_out(int mode, logic [7:0] rnd, int v);
    logic [2:0] b;
    b = 3'(v);
    case (mode)
      0:       return &b;
      1:       return |b;
      2:       return 1'b0;
      default: return rnd[b];
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int H  = (g == 0) ? 4 : 1;
    localparam int PH = P * H;

    // m_pos: -1 idle, 0..PH-1 clocks into the sweep, PH the done cycle.
    int         m_pos  = -1;
    logic [7:0] m_tbl  = '0;
    int         m_err  = 0;
    bit         m_fv   = 1'b0;
    int         m_fvec = 0;
    bit         m_pass = 1'b0;

    assign dut_o_w[g] = gate_out(mode_s[g], rnd_s[g], int'(stim_w[g]));

    gate_exerciser #(.N_INPUTS(N), .HOLD_CYCLES(H)) u_dut (
      .clk        (clk),
      .rst        (rst_s[g]),
      .start      (start_s[g]),
      .exp_table  (tbl_s[g]),
      .dut_o      (dut_o_w[g]),
      .stim       (stim_w[g]),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .pass       (pass_w[g]),
      .err_count  (err_w[g]),
      .fail_valid (fv_w[g]),
      .fail_vec   (fvec_w[g])
    );

    always @(posedge clk) begin
      if (rst_s[g]) begin
        m_pos = -1; m_err = 0; m_fv = 1'b0; m_fvec = 0; m_pass = 1'b0;
      end else if (m_pos < 0) begin
        if (start_s[g]) begin
          m_pos = 0; m_tbl = tbl_s[g]; m_err = 0; m_fv = 1'b0; m_fvec = 0; m_pass = 1'b0;
        end
      end else if (m_pos < PH) begin
        if ((m_pos + 1) % H == 0 &&
            gate_out(mode_s[g], rnd_s[g], m_pos / H) != m_tbl[m_pos / H]) begin
          m_err++;
          if (!m_fv) begin
            m_fv = 1'b1;
            m_fvec = m_pos / H;
          end
        end
        m_pos++;
        if (m_pos == PH) m_pass = (m_err == 0);
      end else begin
        m_pos = -1;
      end
    end

    always @(negedge clk) begin
      if (cmp_en) begin
        bit e_busy;
        bit e_done;
        int e_stim;
        e_busy = (m_pos >= 0 && m_pos < PH);
        e_done = (m_pos == PH);
        e_stim = e_busy ? m_pos / H : (e_done ? P - 1 : 0);
        check("stim", g, int'(stim_w[g]), e_stim);
        check("busy", g, int'(busy_w[g]), int'(e_busy));
        check("done", g, int'(done_w[g]), int'(e_done));
        check("pass", g, int'(pass_w[g]), int'(m_pass));
        check("err_count", g, int'(err_w[g]), m_err);
        check("fail_valid", g, int'(fv_w[g]), int'(m_fv));
        check("fail_vec", g, int'(fvec_w[g]), m_fvec);
      end
    end
  end

  task automatic do_start(input int g, input logic [7:0] tbl);
    @(negedge clk);
    tbl_s[g]   = tbl;
    start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;
  endtask

  // Returns the clock index (start cycle = 0) of the done pulse, or -1 if none within the budget.
  task automatic wait_done(input int g, input int start_at, input int rst_at,
                           input bit scramble, output int cyc_o);
    int cyc;
    cyc   = 1;
    cyc_o = -1;
    while (cyc <= 60) begin
      stim_hist[cyc] = int'(stim_w[g]);
      if (rst_at > 0 && cyc == rst_at + 1) begin
        check("rst_busy", g, int'(busy_w[g]), 0);
        check("rst_stim", g, int'(stim_w[g]), 0);
        check("rst_err", g, int'(err_w[g]), 0);
      end
      if (done_w[g]) begin
        cyc_o = cyc;
        break;
      end
      if (cyc == start_at) start_s[g] = 1'b1;
      if (cyc == rst_at) rst_s[g] = 1'b1;
      if (scramble) tbl_s[g] = 8'($urandom);
      @(negedge clk);
      start_s[g] = 1'b0;
      rst_s[g]   = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] t;
    for (int g = 0; g < 2; g++) begin
      start_s[g] = 1'b0; rst_s[g] = 1'b1; tbl_s[g] = '0; mode_s[g] = 0; rnd_s[g] = '0;
    end
    repeat (3) @(negedge clk);
    rst_s[0] = 1'b0;
    rst_s[1] = 1'b0;
    cmp_en   = 1'b1;
    check("reset_busy", 0, int'(busy_w[0]), 0);
    check("reset_stim", 0, int'(stim_w[0]), 0);
    check("reset_err", 0, int'(err_w[0]), 0);
    check("reset_fail_valid", 0, int'(fv_w[0]), 0);
    check("reset_pass", 0, int'(pass_w[0]), 0);

    mode_s[0] = 0;
    do_start(0, AND3_TABLE);
    wait_done(0, 0, 0, 1'b0, c);
    check("and3_done_cycle", 0, c, 33);
    check("and3_pass", 0, int'(pass_w[0]), 1);
    check("and3_err", 0, int'(err_w[0]), 0);
    check("and3_fail_valid", 0, int'(fv_w[0]), 0);
    check("model_and3_pass", 0, int'(g_inst[0].m_pass), 1);
    check("hold_first", 0, stim_hist[1], 0);
    check("hold_last_of_0", 0, stim_hist[4], 0);
    check("hold_first_of_1", 0, stim_hist[5], 1);
    check("hold_last_of_7", 0, stim_hist[32], 7);
    @(negedge clk);
    check("stim_after_done", 0, int'(stim_w[0]), 0);
    check("done_one_cycle", 0, int'(done_w[0]), 0);
    check("pass_held_idle", 0, int'(pass_w[0]), 1);

    mode_s[0] = 1;
    do_start(0, AND3_TABLE);
    wait_done(0, 10, 0, 1'b0, c);
    check("or3_done_cycle", 0, c, 33);
    check("or3_pass", 0, int'(pass_w[0]), 0);
    check("or3_err", 0, int'(err_w[0]), 6);
    check("or3_fail_vec", 0, int'(fvec_w[0]), 1);
    check("or3_fail_valid", 0, int'(fv_w[0]), 1);
    check("model_or3_err", 0, g_inst[0].m_err, 6);

    mode_s[0] = 0;
    do_start(0, AND3_TABLE);
    wait_done(0, 0, 15, 1'b0, c);
    check("no_done_after_rst", 0, c, -1);
    do_start(0, AND3_TABLE);
    wait_done(0, 0, 0, 1'b0, c);
    check("restart_done_cycle", 0, c, 33);
    check("restart_pass", 0, int'(pass_w[0]), 1);

    repeat (6) begin
      mode_s[0] = 3;
      rnd_s[0]  = 8'($urandom);
      t         = ($urandom_range(0, 1) == 0) ? rnd_s[0] : 8'($urandom);
      do_start(0, t);
      wait_done(0, $urandom_range(2, 32), 0, 1'b1, c);
      check("rand_done_cycle", 0, c, 33);
    end

    mode_s[1] = 2;
    do_start(1, AND3_TABLE);
    wait_done(1, 0, 0, 1'b0, c);
    check("hold1_done_cycle", 1, c, 9);
    check("hold1_err", 1, int'(err_w[1]), 1);
    check("hold1_fail_vec", 1, int'(fvec_w[1]), 7);
    check("hold1_pass", 1, int'(pass_w[1]), 0);
    check("model_hold1_fvec", 1, g_inst[1].m_fvec, 7);

    repeat (6) begin
      mode_s[1] = 3;
      rnd_s[1]  = 8'($urandom);
      do_start(1, 8'($urandom));
      wait_done(1, $urandom_range(2, 8), 0, 1'b1, c);
      check("rand_hold1_done_cycle", 1, c, 9);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gate_exerciser.md
GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 The block SHALL have parameter N_INPUTS, default 3, giving the stimulus width of the gate under test (1..8).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, giving clocks each vector is held (>=1).
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 The block SHALL have port exp_table  input  2**N_INPUTS  expected gate output, bit k for stimulus value k.
REQ-007 The block SHALL have port dut_o  input  1  output of the gate under test.
REQ-008 The block SHALL have port stim  output  N_INPUTS  stimulus vector, bit 0 drives i1, bit 1 drives i2, and so on.
REQ-009 The block SHALL have port busy  output  1  sweep in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse at sweep end.
REQ-011 The block SHALL have port pass  output  1  last sweep had zero mismatches, valid from done.
REQ-012 The block SHALL have port err_count  output  N_INPUTS+1  mismatches in the last or current sweep.
REQ-013 The block SHALL have port fail_valid  output  1  at least one mismatch has been captured.
REQ-014 The block SHALL have port fail_vec  output  N_INPUTS  stimulus value of the first mismatch.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE and DONE.
REQ-016 In IDLE with start=1, the block SHALL, on the next edge:
- enter DRIVE
- set stim=0, hold count=0, err_count=0, fail_valid=0, fail_vec=0
- latch exp_table internally
REQ-017 exp_table changes after the start edge SHALL NOT affect the running sweep.
REQ-018 In DRIVE, busy SHALL be 1 and each stim value SHALL be held for exactly HOLD_CYCLES clocks.
REQ-019 dut_o SHALL be sampled only on the last hold clock of each vector, when hold count = HOLD_CYCLES-1.
REQ-020 On that sample, a mismatch (dut_o != latched_table[stim]) SHALL increment err_count.
REQ-021 If fail_valid=0 on a mismatch, the block SHALL set fail_valid=1 and fail_vec=stim; later mismatches SHALL NOT overwrite fail_vec.
REQ-022 After sampling stim < 2**N_INPUTS-1, stim SHALL increment by 1 and hold count SHALL clear.
REQ-023 After sampling stim = 2**N_INPUTS-1, the FSM SHALL enter DONE; stim SHALL NOT wrap during DRIVE.
REQ-024 In DONE, for exactly one cycle, the outputs SHALL be:
- done=1, busy=0
- pass=(final err_count==0), including the last sample
REQ-025 From DONE, the FSM SHALL return to IDLE and stim SHALL return to 0.
REQ-026 From start to done SHALL be exactly 1 + (2**N_INPUTS)*HOLD_CYCLES clocks.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 err_count, pass, fail_valid and fail_vec SHALL hold their values in IDLE until the next accepted start.
REQ-029 err_count SHALL count to at most 2**N_INPUTS without overflow.

Reset
REQ-030 rst=1 SHALL, at the next edge, set:
- FSM=IDLE, hold count=0
- stim=0, busy=0, done=0, pass=0
- err_count=0, fail_valid=0, fail_vec=0
REQ-031 rst SHALL override start in the same cycle.
REQ-032 rst during DRIVE SHALL abort the sweep with no done pulse.

Structure
REQ-033 Package gate_ex_pkg SHALL hold:
- the FSM state enum
- default N_INPUTS/HOLD_CYCLES constants
- truth-table constants AND3_TABLE=8'b1000_0000 and OR3_TABLE=8'b1111_1110
REQ-034 The hold timer SHALL be one sub-module, hold_counter: clear, enable, terminal-count output.
REQ-035 The rest of the design SHALL be a single module.

Verification
REQ-036 Bench SHALL cover: reset, then start with exp_table=AND3_TABLE and a correct AND3 -> done at clock 33, pass=1, err_count=0, fail_valid=0.
REQ-037 Bench SHALL cover: OR3 as DUT with exp_table=AND3_TABLE -> pass=0, err_count=6, fail_vec=3'b001.
REQ-038 Bench SHALL cover: stim held 4 clocks per value 0..7 in order, sampled on 4th -> no change mid-hold, stim=0 after DONE.
REQ-039 Bench SHALL cover: start pulsed at clock 10 of a sweep -> ignored, done still at clock 33.
REQ-040 Bench SHALL cover: rst asserted at clock 15 of a sweep -> all outputs reset next edge, no done pulse; fresh start then completes normally.
REQ-041 Bench SHALL cover: HOLD_CYCLES=1 and dut_o tied to 0 with AND3_TABLE -> done at clock 9, err_count=1, fail_vec=3'b111.
